// File: rtl/adder_key_loader_32.sv
// -----------------------------------------------------------------------------
// adder_key_loader_32
//
// Front/back-end wrapper around the 32-bit locked carry-lookahead adder.
// A 64-bit unlock key is shifted in serially (LSB first) into a shadow
// register. The adder's key input changes only when a complete key has
// arrived, so the adder never sees a partial key. Operands are registered
// into the adder through a valid/ready handshake (stage 1). The adder's
// combinational result is captured into a backpressured output register
// (stage 2).
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   key_start_i   request a (re)load of the key
//   key_bit_i     serial key bit, LSB first
//   key_valid_i   key_bit_i is valid this cycle
//   key_loaded_o  key register holds a complete key
//   keyinput_o    key presented to the adder
//   op_valid_i    operand pair valid
//   op_ready_o    block accepts an operand pair (combinational)
//   add1_in_i     operand A
//   add2_in_i     operand B
//   add1_o        registered operand A to the adder
//   add2_o        registered operand B to the adder
//   result_i      adder result (carry-out in bit DATA_WIDTH)
//   sum_valid_o   sum_o holds a result
//   sum_ready_i   consumer takes sum_o
//   sum_o         captured result
// -----------------------------------------------------------------------------
module adder_key_loader_32 #(
  parameter int KEY_WIDTH  = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  key_start_i,
  input  logic                  key_bit_i,
  input  logic                  key_valid_i,
  output logic                  key_loaded_o,
  output logic [KEY_WIDTH-1:0]  keyinput_o,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  input  logic [DATA_WIDTH-1:0] add1_in_i,
  input  logic [DATA_WIDTH-1:0] add2_in_i,
  output logic [DATA_WIDTH-1:0] add1_o,
  output logic [DATA_WIDTH-1:0] add2_o,
  input  logic [DATA_WIDTH:0]   result_i,
  output logic                  sum_valid_o,
  input  logic                  sum_ready_i,
  output logic [DATA_WIDTH:0]   sum_o
);

  localparam int CNT_W = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KEY_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    ARMED = 2'd3
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [KEY_WIDTH-1:0]   shadow_q;
  logic [KEY_WIDTH-1:0]   key_full;
  logic                   s1_valid_q;

  logic s2_free;
  logic bit_accept;
  logic last_bit;
  logic pipe_empty;
  logic op_accept;
  logic s1_to_s2;

  // Stage 2 can take a new value if it is empty or is being emptied now.
  // A restart request in LOAD outranks a bit arriving in the same cycle.
  assign s2_free    = !sum_valid_o || sum_ready_i;
  assign bit_accept = (state_q == LOAD) && key_valid_i && !key_start_i;
  assign last_bit   = bit_accept && (bit_cnt_q == LAST_IDX);
  assign pipe_empty = !s1_valid_q && !sum_valid_o;
  assign op_accept  = op_valid_i && op_ready_o;
  assign s1_to_s2   = s1_valid_q && s2_free;

  // The completed key is the shadow word with the final (top) bit merged in
  // from the serial input, so the key is published on the same edge that
  // accepts its last bit.
  always_comb begin
    key_full                = shadow_q;
    key_full[KEY_WIDTH-1]   = key_bit_i;
  end

  // State register for the key-management FSM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A reload request from ARMED first drains the pipeline
  // so in-flight operands finish under the key they were issued with; extra
  // start requests during DRAIN are simply ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (key_start_i) state_d = LOAD;
      LOAD:    if (last_bit)    state_d = ARMED;
      ARMED:   if (key_start_i) state_d = DRAIN;
      DRAIN:   if (pipe_empty)  state_d = LOAD;
      default:                  state_d = IDLE;
    endcase
  end

  // Operand ready only exists while armed: stage 1 must be empty or about
  // to move into stage 2.
  always_comb begin
    op_ready_o = 1'b0;
    if (state_q == ARMED) begin
      op_ready_o = !s1_valid_q || s2_free;
    end
  end

  // Key shift register, bit counter and the published key. The published
  // key is only written when a full key has been collected; otherwise it
  // keeps the previous complete key.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt_q    <= '0;
      shadow_q     <= '0;
      keyinput_o   <= '0;
      key_loaded_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_start_i) begin
            bit_cnt_q <= '0;
            shadow_q  <= '0;
          end
        end
        LOAD: begin
          if (key_start_i) begin
            bit_cnt_q <= '0;
            shadow_q  <= '0;
          end else if (key_valid_i) begin
            shadow_q[bit_cnt_q] <= key_bit_i;
            if (bit_cnt_q == LAST_IDX) begin
              keyinput_o   <= key_full;
              key_loaded_o <= 1'b1;
              bit_cnt_q    <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            key_loaded_o <= 1'b0;
            shadow_q     <= '0;
            bit_cnt_q    <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Two-stage operand/result pipeline. Stage 1 holds the operands driving
  // the adder; stage 2 captures the adder's result. Stage 1 moves forward
  // whenever stage 2 is free, which lets DRAIN finish in-flight work even
  // though no new operands are accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      add1_o      <= '0;
      add2_o      <= '0;
      s1_valid_q  <= 1'b0;
      sum_valid_o <= 1'b0;
      sum_o       <= '0;
    end else begin
      if (op_accept) begin
        add1_o <= add1_in_i;
        add2_o <= add2_in_i;
      end

      if (op_accept) begin
        s1_valid_q <= 1'b1;
      end else if (s1_to_s2) begin
        s1_valid_q <= 1'b0;
      end

      if (s1_to_s2) begin
        sum_o       <= result_i;
        sum_valid_o <= 1'b1;
      end else if (sum_ready_i) begin
        sum_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_key_loader_32.sv
// -----------------------------------------------------------------------------
// tb_adder_key_loader_32
//
// Self-checking bench for adder_key_loader_32. An ideal (unlocked) adder is
// modelled by driving result_i from add1_o + add2_o. Every accepted operand
// pair pushes its arithmetic sum into a scoreboard queue; a monitor pops and
// compares whenever a result is handed over on sum_valid_o/sum_ready_i.
// -----------------------------------------------------------------------------
module tb_adder_key_loader_32;

  localparam int KW = 64;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          key_start_i = 1'b0;
  logic          key_bit_i = 1'b0;
  logic          key_valid_i = 1'b0;
  logic          key_loaded_o;
  logic [KW-1:0] keyinput_o;
  logic          op_valid_i = 1'b0;
  logic          op_ready_o;
  logic [DW-1:0] add1_in_i = '0;
  logic [DW-1:0] add2_in_i = '0;
  logic [DW-1:0] add1_o;
  logic [DW-1:0] add2_o;
  logic [DW:0]   result_i;
  logic          sum_valid_o;
  logic          sum_ready_i = 1'b0;
  logic [DW:0]   sum_o;

  int errors = 0;
  int checks = 0;
  int accepts = 0;
  int run_len = 0;
  int max_run = 0;
  logic [DW:0] exp_q[$];

  localparam logic [KW-1:0] KEY_A    = 64'hA5A5_0F0F_1234_8001;
  localparam logic [KW-1:0] KEY_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  adder_key_loader_32 #(.KEY_WIDTH(KW), .DATA_WIDTH(DW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .key_start_i  (key_start_i),
    .key_bit_i    (key_bit_i),
    .key_valid_i  (key_valid_i),
    .key_loaded_o (key_loaded_o),
    .keyinput_o   (keyinput_o),
    .op_valid_i   (op_valid_i),
    .op_ready_o   (op_ready_o),
    .add1_in_i    (add1_in_i),
    .add2_in_i    (add2_in_i),
    .add1_o       (add1_o),
    .add2_o       (add2_o),
    .result_i     (result_i),
    .sum_valid_o  (sum_valid_o),
    .sum_ready_i  (sum_ready_i),
    .sum_o        (sum_o)
  );

  // Ideal unlocked adder sitting behind the wrapper.
  assign result_i = {1'b0, add1_o} + {1'b0, add2_o};

  always #5 clk = ~clk;

  // Watchdog so the run always ends even if the DUT never responds.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [DW-1:0] a,
                               input logic [DW-1:0] b);
    op_valid_i = valid;
    add1_in_i  = a;
    add2_in_i  = b;
  endtask

  // Scoreboard monitor: samples mid-cycle, when inputs and registered
  // outputs are stable, and records what the next rising edge will transfer.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (sum_valid_o) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (sum_valid_o && sum_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sum_unexpected: got 0x%0h, expected no result", sum_o);
        end else begin
          checkOutput("sum_o", sum_o, exp_q.pop_front());
        end
      end
      if (op_valid_i && op_ready_o) begin
        exp_q.push_back({1'b0, add1_in_i} + {1'b0, add2_in_i});
        accepts++;
      end
    end
  end

  // Shifts count bits of k (LSB first) with random idle gaps. Until the
  // final bit of a completing load, the published key must stay at hold_key.
  task automatic sendKeyBits(input logic [KW-1:0] k, input int count,
                             input logic [KW-1:0] hold_key, input bit completes);
    for (int i = 0; i < count; i++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        key_valid_i = 1'b0;
        key_bit_i   = $urandom_range(0, 1);
        tick();
        checkOutput("key_hidden_gap", keyinput_o, hold_key);
      end
      key_valid_i = 1'b1;
      key_bit_i   = k[i];
      tick();
      key_valid_i = 1'b0;
      if (completes && (i == count - 1)) begin
        checkOutput("key_complete", keyinput_o, k);
        checkOutput("key_loaded_set", key_loaded_o, 1);
      end else begin
        checkOutput("key_hidden", keyinput_o, hold_key);
        checkOutput("key_loaded_low", key_loaded_o, 0);
      end
    end
  endtask

  task automatic waitEmpty(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || sum_valid_o) && n < 50) begin
      tick();
      n++;
    end
    checkOutput(name, exp_q.size(), 0);
  endtask

  initial begin
    logic [DW-1:0] pa[3];
    logic [DW-1:0] pb[3];
    logic [KW-1:0] rkey;
    int idx;
    int n;
    logic acc;

    // Reset values
    rst_i = 1'b1;
    tick();
    tick();
    checkOutput("rst_keyinput", keyinput_o, 0);
    checkOutput("rst_key_loaded", key_loaded_o, 0);
    checkOutput("rst_op_ready", op_ready_o, 0);
    checkOutput("rst_sum_valid", sum_valid_o, 0);
    checkOutput("rst_sum", sum_o, 0);
    rst_i = 1'b0;
    tick();
    checkOutput("idle_op_ready", op_ready_o, 0);

    // First key load from IDLE
    key_start_i = 1'b1;
    tick();
    key_start_i = 1'b0;
    sendKeyBits(KEY_A, KW, '0, 1'b1);

    // Single operation: carry-out and two-cycle latency
    sum_ready_i = 1'b1;
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    checkOutput("armed_op_ready", op_ready_o, 1);
    tick();
    applyStimulus(1'b0, '0, '0);
    checkOutput("lat_add1", add1_o, 32'hFFFF_FFFF);
    checkOutput("lat_early_valid", sum_valid_o, 0);
    tick();
    checkOutput("lat_sum_valid", sum_valid_o, 1);
    checkOutput("lat_sum", sum_o, 33'h1_0000_0000);
    tick();
    checkOutput("lat_sum_clear", sum_valid_o, 0);

    // Back-to-back stream of 8 pairs
    accepts = 0;
    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, $urandom, $urandom);
      tick();
    end
    applyStimulus(1'b0, '0, '0);
    checkOutput("stream_accepts", accepts, 8);
    waitEmpty("stream_drained");
    checkOutput("stream_run", max_run, 8);

    // Backpressure: three pairs offered, only two fit
    sum_ready_i = 1'b0;
    accepts = 0;
    for (int i = 0; i < 3; i++) begin
      pa[i] = $urandom;
      pb[i] = $urandom;
    end
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 3) applyStimulus(1'b1, pa[idx], pb[idx]);
      else         applyStimulus(1'b0, '0, '0);
      @(negedge clk);
      acc = op_valid_i && op_ready_o;
      tick();
      if (acc) idx++;
    end
    checkOutput("bp_accepts", accepts, 2);
    checkOutput("bp_ready_low", op_ready_o, 0);
    checkOutput("bp_sum_valid", sum_valid_o, 1);
    sum_ready_i = 1'b1;
    n = 0;
    while (idx < 3 && n < 10) begin
      applyStimulus(1'b1, pa[idx], pb[idx]);
      @(negedge clk);
      acc = op_valid_i && op_ready_o;
      tick();
      if (acc) idx++;
      n++;
    end
    applyStimulus(1'b0, '0, '0);
    checkOutput("bp_all_accepted", accepts, 3);
    waitEmpty("bp_drained");

    // Reload while two results are in flight
    sum_ready_i = 1'b0;
    applyStimulus(1'b1, $urandom, $urandom);
    tick();
    applyStimulus(1'b1, $urandom, $urandom);
    tick();
    applyStimulus(1'b0, '0, '0);
    checkOutput("busy_sum_valid", sum_valid_o, 1);
    checkOutput("busy_ready_low", op_ready_o, 0);
    key_start_i = 1'b1;
    tick();
    tick();
    tick();
    key_start_i = 1'b0;
    checkOutput("drain_loaded_held", key_loaded_o, 1);
    checkOutput("drain_key_held", keyinput_o, KEY_A);
    sum_ready_i = 1'b1;
    applyStimulus(1'b1, $urandom, $urandom);
    n = 0;
    while (key_loaded_o && n < 20) begin
      tick();
      checkOutput("drain_ready_low", op_ready_o, 0);
      if (sum_valid_o) checkOutput("drain_no_early_load", key_loaded_o, 1);
      n++;
    end
    applyStimulus(1'b0, '0, '0);
    checkOutput("drain_to_load", key_loaded_o, 0);
    checkOutput("drain_results_done", exp_q.size(), 0);
    checkOutput("load_key_held", keyinput_o, KEY_A);

    // Restart mid-load: the bit presented with the restart is dropped
    rkey = {$urandom, $urandom};
    sendKeyBits(rkey, 30, KEY_A, 1'b0);
    key_start_i = 1'b1;
    key_valid_i = 1'b1;
    key_bit_i   = 1'b0;
    tick();
    key_start_i = 1'b0;
    key_valid_i = 1'b0;
    checkOutput("restart_key_held", keyinput_o, KEY_A);
    sendKeyBits(KEY_ONES, KW, KEY_A, 1'b1);

    // Randomised traffic with random backpressure under the new key
    for (int c = 0; c < 40; c++) begin
      sum_ready_i = $urandom_range(0, 1);
      applyStimulus($urandom_range(0, 1), $urandom, $urandom);
      tick();
    end
    applyStimulus(1'b0, '0, '0);
    sum_ready_i = 1'b1;
    waitEmpty("random_drained");

    // Reset during DRAIN with a full pipeline
    sum_ready_i = 1'b0;
    applyStimulus(1'b1, $urandom | 32'h1, $urandom);
    tick();
    applyStimulus(1'b1, $urandom, $urandom);
    tick();
    applyStimulus(1'b0, '0, '0);
    key_start_i = 1'b1;
    tick();
    key_start_i = 1'b0;
    exp_q.delete();
    rst_i = 1'b1;
    tick();
    checkOutput("mid_rst_keyinput", keyinput_o, 0);
    checkOutput("mid_rst_key_loaded", key_loaded_o, 0);
    checkOutput("mid_rst_op_ready", op_ready_o, 0);
    checkOutput("mid_rst_sum_valid", sum_valid_o, 0);
    checkOutput("mid_rst_sum", sum_o, 0);
    checkOutput("mid_rst_add1", add1_o, 0);
    rst_i = 1'b0;
    sum_ready_i = 1'b1;
    tick();
    checkOutput("post_rst_op_ready", op_ready_o, 0);
    checkOutput("post_rst_sum_valid", sum_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_key_loader_32.md
# adder_key_loader_32

Sequential front/back-end wrapper for the 32-bit locked carry-lookahead adder. Upstream, it assembles the 64-bit unlock key from a serial bit stream and presents it to the adder's `keyinput` only once all 64 bits have arrived. It also registers operands into the adder through a valid/ready handshake. Downstream, it captures the adder's 33-bit result into a backpressured output register.

## Interface
- `KEY_WIDTH`, default 64: key length in bits; also the serial bit count.
- `DATA_WIDTH`, default 32: operand width; the result is `DATA_WIDTH+1` bits.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `key_start_i`  in  1  request to begin a (re)load of the key.
- `key_bit_i`  in  1  serial key bit, LSB first.
- `key_valid_i`  in  1  `key_bit_i` is valid this cycle.
- `key_loaded_o`  out  1  key register holds a complete key.
- `keyinput_o`  out  KEY_WIDTH  key to the adder's `keyinput`.
- `op_valid_i`  in  1  operand pair is valid.
- `op_ready_o`  out  1  block accepts an operand pair.
- `add1_in_i`, `add2_in_i`  in  DATA_WIDTH  operands.
- `add1_o`, `add2_o`  out  DATA_WIDTH  registered operands to the adder's `add1_i`/`add2_i`.
- `result_i`  in  DATA_WIDTH+1  adder's `result_o` (combinational from `add1_o`/`add2_o`).
- `sum_valid_o`  out  1  `sum_o` holds a result.
- `sum_ready_i`  in  1  consumer takes `sum_o`.
- `sum_o`  out  DATA_WIDTH+1  captured result.

## Operation
- **States:** IDLE, LOAD, DRAIN, ARMED.
- **Reset:** state IDLE; bit counter 0; shadow register 0; `keyinput_o`=0; `key_loaded_o`=0; `add1_o`/`add2_o`=0; stage-1 valid=0; `sum_valid_o`=0; `sum_o`=0.
- **IDLE:**
  - `key_start_i` → LOAD; counter 0; shadow cleared.
  - `op_ready_o`=0.
- **LOAD:**
  - Each cycle with `key_valid_i`=1: shadow[counter] <= `key_bit_i`; counter++.
  - The accept that takes the counter from KEY_WIDTH-1 to KEY_WIDTH copies the full shadow word (including this bit) to `keyinput_o`, sets `key_loaded_o`=1, clears the counter, and goes to ARMED.
  - `key_start_i` in LOAD restarts the load: counter 0, shadow cleared. If `key_valid_i` is high in the same cycle, restart wins and the bit is discarded.
  - `keyinput_o` never shows a partial key.
- **ARMED:**
  - s2_free = !`sum_valid_o` | `sum_ready_i`.
  - `op_ready_o` = !s1_valid | s2_free.
  - Operand accept (`op_valid_i` & `op_ready_o`): `add1_o`/`add2_o` <= inputs; s1_valid <= 1.
  - If s1_valid & s2_free: `sum_o` <= `result_i`; `sum_valid_o` <= 1. Stage 1 empties unless refilled in the same cycle.
  - `sum_ready_i` with no new capture: `sum_valid_o` <= 0.
  - `key_start_i` → DRAIN; `op_ready_o` is 0 from the next cycle onward.
- **DRAIN:**
  - No new operands accepted. In-flight data completes with the old key; `keyinput_o` is held.
  - When s1_valid=0 and `sum_valid_o`=0 → LOAD. `key_loaded_o`=0 on LOAD entry; shadow cleared.
  - A `key_start_i` received during DRAIN is absorbed (no extra effect).
- **Width rules:** `result_i` and `sum_o` are DATA_WIDTH+1 bits; the carry-out is bit DATA_WIDTH. The block performs no arithmetic; correctness depends entirely on the key.
- **Reset mid-operation:** any state, including a partial LOAD or a full pipeline, returns to the reset values in one cycle; in-flight data is lost.

## Timing
- Key: the cycle after the 64th accepted bit, `keyinput_o` and `key_loaded_o` are valid; the minimum load is 64 cycles.
- Operand accepted at edge N: `add1_o`/`add2_o` valid after edge N. `sum_o` is captured at edge N+1 if stage 2 is free, so latency is 2 cycles.
- Sustained throughput is 1 result/cycle while `sum_ready_i`=1.
- With `sum_ready_i`=0: at most 2 results buffered (stage 1 + stage 2). `op_ready_o` drops when both are full.
- `op_ready_o` is combinational from state, s1_valid, `sum_valid_o`, and `sum_ready_i`. All other outputs are registered.

## Test plan
- **Reset values:** hold `rst_i` 2 cycles → `keyinput_o`=0, `key_loaded_o`=0, `op_ready_o`=0, `sum_valid_o`=0, `sum_o`=0.
- **Key load:** pulse `key_start_i`, then shift 0xA5A5_0F0F_1234_8001 LSB first with gaps in `key_valid_i`. `keyinput_o` stays 0 until the cycle after bit 63, then equals the value; `key_loaded_o`=1.
- **Restart:** after 30 bits, assert `key_start_i` together with `key_valid_i`=1. That bit is dropped, then load 0xFFFF_FFFF_FFFF_FFFF → `keyinput_o`=all ones after exactly 64 further accepted bits.
- **Datapath:** bench drives `result_i` from a golden model (`add1_o`+`add2_o`). Send 0xFFFFFFFF+0x00000001 → `sum_o`=0x1_00000000 two cycles after accept. Back-to-back stream of 8 pairs → 8 consecutive results, 1 per cycle.
- **Backpressure:** `sum_ready_i`=0 with 3 pairs offered → 2 accepted, `op_ready_o`=0. Release → results delivered in order, none lost or duplicated.
- **Reload while busy:** with 2 results in flight, assert `key_start_i`. Both results complete with the old key and `op_ready_o` stays 0. LOAD begins only after `sum_valid_o` drops. A reset asserted during DRAIN clears everything within 1 cycle.
